// File: rtl/alu_pipe.sv
// Pipelined 6502-style ALU: N/Z/C/V flags with per-op write mask and optional BCD add/sub.
// Latency LATENCY (1 or 2) cycles, one op per cycle; results hold while out_ready is low.
module alu_pipe #(
    parameter int WIDTH      = 8,
    parameter int LATENCY    = 1,
    parameter int DECIMAL_EN = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             in_c,
    input  logic             in_v,
    input  logic             in_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic [3:0]       flag_we
);
    localparam int NIB = WIDTH / 4;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3,
                           OP_XOR = 4'd4,  OP_INC = 4'd5,  OP_DEC = 4'd6,  OP_SHR = 4'd7,
                           OP_SHL = 4'd8,  OP_RTR = 4'd9,  OP_RTL = 4'd10, OP_CMP = 4'd11,
                           OP_LD  = 4'd12, OP_BIT = 4'd13;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             n;
        logic             z;
        logic             c;
        logic             v;
        logic [3:0]       we;
    } res_t;

    res_t             res_d;
    res_t             out_res;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH:0]   cmp_s;
    logic [WIDTH-1:0] dec_r;
    logic             dec_c;
    logic             dec_sub;
    logic             dec_en;
    logic [5:0]       nib_t;

    assign add_s   = {1'b0, operand1} + {1'b0, operand2} + {{WIDTH{1'b0}}, in_c};
    assign sub_s   = {1'b0, operand1} + {1'b0, ~operand2} + {{WIDTH{1'b0}}, in_c};
    assign cmp_s   = {1'b0, operand1} + {1'b0, ~operand2} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_sub = (op == OP_SUB);
    assign dec_en  = (DECIMAL_EN != 0) && in_d && (op == OP_ADD || op == OP_SUB);

    // BCD ripple: each nibble is adjusted and its decimal carry feeds the next one up
    always_comb begin
        dec_r = '0;
        dec_c = in_c;
        nib_t = '0;
        for (int i = 0; i < NIB; i++) begin
            if (dec_sub) begin
                nib_t = {2'b00, operand1[4*i +: 4]} + {2'b00, ~operand2[4*i +: 4]} + {5'b0, dec_c};
                dec_c = nib_t[4];
                dec_r[4*i +: 4] = dec_c ? nib_t[3:0] : nib_t[3:0] - 4'd6;
            end else begin
                nib_t = {2'b00, operand1[4*i +: 4]} + {2'b00, operand2[4*i +: 4]} + {5'b0, dec_c};
                if (nib_t > 6'd9) begin
                    nib_t = nib_t + 6'd6;
                end
                dec_c = (nib_t > 6'd15);
                dec_r[4*i +: 4] = nib_t[3:0];
            end
        end
    end

    always_comb begin
        res_d    = '0;
        res_d.c  = in_c;
        res_d.v  = in_v;
        res_d.we = 4'b0000;
        case (op)
            OP_ADD: begin
                res_d.r  = add_s[WIDTH-1:0];
                res_d.c  = add_s[WIDTH];
                res_d.v  = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (add_s[WIDTH-1] != operand1[WIDTH-1]);
                res_d.we = 4'b1111;
            end
            OP_SUB: begin
                res_d.r  = sub_s[WIDTH-1:0];
                res_d.c  = sub_s[WIDTH];
                res_d.v  = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (sub_s[WIDTH-1] != operand1[WIDTH-1]);
                res_d.we = 4'b1111;
            end
            OP_CMP: begin
                res_d.r  = cmp_s[WIDTH-1:0];
                res_d.c  = cmp_s[WIDTH];
                res_d.we = 4'b1110;
            end
            OP_AND: begin res_d.r = operand1 & operand2;  res_d.we = 4'b1100; end
            OP_OR:  begin res_d.r = operand1 | operand2;  res_d.we = 4'b1100; end
            OP_XOR: begin res_d.r = operand1 ^ operand2;  res_d.we = 4'b1100; end
            OP_INC: begin res_d.r = operand1 + 1'b1;      res_d.we = 4'b1100; end
            OP_DEC: begin res_d.r = operand1 - 1'b1;      res_d.we = 4'b1100; end
            OP_LD:  begin res_d.r = operand1;             res_d.we = 4'b1100; end
            OP_SHR: begin
                res_d.r  = operand1 >> 1;
                res_d.c  = operand1[0];
                res_d.we = 4'b1110;
            end
            OP_SHL: begin
                res_d.r  = operand1 << 1;
                res_d.c  = operand1[WIDTH-1];
                res_d.we = 4'b1110;
            end
            OP_RTR: begin
                res_d.r  = {in_c, operand1[WIDTH-1:1]};
                res_d.c  = operand1[0];
                res_d.we = 4'b1110;
            end
            OP_RTL: begin
                res_d.r  = {operand1[WIDTH-2:0], in_c};
                res_d.c  = operand1[WIDTH-1];
                res_d.we = 4'b1110;
            end
            OP_BIT: begin
                res_d.r  = operand1 & operand2;
                res_d.v  = operand2[WIDTH-2];
                res_d.we = 4'b1101;
            end
            default: ;
        endcase
        // V stays from the binary path even in decimal mode
        if (dec_en) begin
            res_d.r = dec_r;
            res_d.c = dec_c;
        end
        res_d.n = (op == OP_BIT) ? operand2[WIDTH-1] : res_d.r[WIDTH-1];
        res_d.z = (res_d.r == '0);
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            res_t s1_q, s2_q;
            logic s1_vld_q, s2_vld_q;
            logic s2_adv;

            assign s2_adv    = !s2_vld_q || out_ready;
            assign in_ready  = !s1_vld_q || s2_adv;
            assign out_valid = s2_vld_q;
            assign out_res   = s2_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_vld_q <= 1'b0;
                    s2_vld_q <= 1'b0;
                    s1_q     <= '0;
                    s2_q     <= '0;
                end else begin
                    if (flush) begin
                        s1_vld_q <= 1'b0;
                        s2_vld_q <= 1'b0;
                    end else begin
                        if (in_ready) s1_vld_q <= in_valid;
                        if (s2_adv)   s2_vld_q <= s1_vld_q;
                    end
                    if (in_valid && in_ready) s1_q <= res_d;
                    if (s2_adv && s1_vld_q)   s2_q <= s1_q;
                end
            end
        end else begin : g_lat1
            res_t s1_q;
            logic s1_vld_q;

            assign in_ready  = !s1_vld_q || out_ready;
            assign out_valid = s1_vld_q;
            assign out_res   = s1_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_vld_q <= 1'b0;
                    s1_q     <= '0;
                end else begin
                    if (flush) begin
                        s1_vld_q <= 1'b0;
                    end else if (in_ready) begin
                        s1_vld_q <= in_valid;
                    end
                    if (in_valid && in_ready) s1_q <= res_d;
                end
            end
        end
    endgenerate

    assign result  = out_res.r;
    assign flag_n  = out_res.n;
    assign flag_z  = out_res.z;
    assign flag_c  = out_res.c;
    assign flag_v  = out_res.v;
    assign flag_we = out_res.we;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: op/flag table on a 1-stage BCD-enabled instance,
// handshake, stall, flush and reset sequences on a 2-stage binary-only instance.
module tb_alu_pipe;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       c_in, v_in, d_in;

    logic       flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [7:0] result1;
    logic       n1, z1, c1, v1;
    logic [3:0] we1;

    logic       flush2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [7:0] result2;
    logic       n2, z2, c2, v2;
    logic [3:0] we2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .LATENCY(1), .DECIMAL_EN(1)) u_l1 (
        .clk(clk), .reset(reset), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .op(op), .operand1(a), .operand2(b),
        .in_c(c_in), .in_v(v_in), .in_d(d_in),
        .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
        .flag_n(n1), .flag_z(z1), .flag_c(c1), .flag_v(v1), .flag_we(we1)
    );

    alu_pipe #(.WIDTH(8), .LATENCY(2), .DECIMAL_EN(0)) u_l2 (
        .clk(clk), .reset(reset), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .op(op), .operand1(a), .operand2(b),
        .in_c(c_in), .in_v(v_in), .in_d(d_in),
        .out_valid(out_valid2), .out_ready(out_ready2), .result(result2),
        .flag_n(n2), .flag_z(z2), .flag_c(c2), .flag_v(v2), .flag_we(we2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       v;
        logic       d;
        logic [7:0] r;
        logic [3:0] nzcv;
        logic [3:0] we;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       d;
        logic [7:0] r;
    } sop_t;
    sop_t sops[4];

    initial begin
        //            op     A      B      c     v     d     R      NZCV     we
        vecs[0]  = '{4'd0,  8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 8'hA0, 4'b1001, 4'b1111};
        vecs[1]  = '{4'd0,  8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0110, 4'b1111};
        vecs[2]  = '{4'd1,  8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 8'hFF, 4'b1000, 4'b1111};
        vecs[3]  = '{4'd11, 8'h40, 8'h40, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0111, 4'b1110};
        vecs[4]  = '{4'd9,  8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h80, 4'b1010, 4'b1110};
        vecs[5]  = '{4'd13, 8'h0F, 8'hC0, 1'b1, 1'b0, 1'b0, 8'h00, 4'b1111, 4'b1101};
        vecs[6]  = '{4'd2,  8'hF0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h30, 4'b0001, 4'b1100};
        vecs[7]  = '{4'd3,  8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'b0110, 4'b1100};
        vecs[8]  = '{4'd4,  8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 8'hF0, 4'b1000, 4'b1100};
        vecs[9]  = '{4'd5,  8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0100, 4'b1100};
        vecs[10] = '{4'd6,  8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF, 4'b1011, 4'b1100};
        vecs[11] = '{4'd7,  8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 8'h40, 4'b0010, 4'b1110};
        vecs[12] = '{4'd8,  8'h81, 8'h00, 1'b0, 1'b1, 1'b0, 8'h02, 4'b0011, 4'b1110};
        vecs[13] = '{4'd10, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0110, 4'b1110};
        vecs[14] = '{4'd12, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b0, 8'h7F, 4'b0010, 4'b1100};
        vecs[15] = '{4'd14, 8'h55, 8'hAA, 1'b1, 1'b1, 1'b0, 8'h00, 4'b0111, 4'b0000};
        vecs[16] = '{4'd0,  8'h45, 8'h38, 1'b0, 1'b0, 1'b1, 8'h83, 4'b1000, 4'b1111};
        vecs[17] = '{4'd0,  8'h99, 8'h01, 1'b0, 1'b0, 1'b1, 8'h00, 4'b0110, 4'b1111};
        vecs[18] = '{4'd1,  8'h10, 8'h01, 1'b1, 1'b0, 1'b1, 8'h09, 4'b0010, 4'b1111};
        vecs[19] = '{4'd1,  8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 8'h7F, 4'b0011, 4'b1111};
        vecs[20] = '{4'd15, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4'b0101, 4'b0000};

        // In_d must be ignored on the binary-only instance: 0x45+0x38 stays 0x7D
        sops[0] = '{4'd0,  8'h45, 8'h38, 1'b1, 8'h7D};
        sops[1] = '{4'd12, 8'h22, 8'h00, 1'b0, 8'h22};
        sops[2] = '{4'd12, 8'h33, 8'h00, 1'b0, 8'h33};
        sops[3] = '{4'd12, 8'h44, 8'h00, 1'b0, 8'h44};

        reset = 1'b1;
        flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b1;
        flush2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
        op = 4'd0; a = 8'h00; b = 8'h00; c_in = 1'b0; v_in = 1'b0; d_in = 1'b0;

        #1;
        chk("rst_valid", {31'd0, out_valid1}, 32'd0);
        chk("rst_result", {24'd0, result1}, 32'd0);
        chk("rst_flags", {24'd0, n1, z1, c1, v1, we1}, 32'd0);
        chk("rst_valid2", {31'd0, out_valid2}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {30'd0, in_ready1, in_ready2}, 32'd3);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            c_in = vecs[i].c; v_in = vecs[i].v; d_in = vecs[i].d;
            in_valid1 = 1'b1; out_ready1 = 1'b1;
            @(posedge clk);
            #1;
            in_valid1 = 1'b0;
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid1}, 32'd1);
            chk($sformatf("v%0d_result", i), {24'd0, result1}, {24'd0, vecs[i].r});
            chk($sformatf("v%0d_nzcv", i), {28'd0, n1, z1, c1, v1}, {28'd0, vecs[i].nzcv});
            chk($sformatf("v%0d_we", i), {28'd0, we1}, {28'd0, vecs[i].we});
        end

        // Latency-2: nothing after one edge, result after two
        @(negedge clk);
        op = 4'd12; a = 8'h5A; b = 8'h00; c_in = 1'b0; v_in = 1'b0; d_in = 1'b0;
        in_valid2 = 1'b1; out_ready2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        chk("l2_not_yet", {31'd0, out_valid2}, 32'd0);
        @(posedge clk);
        #1;
        chk("l2_valid", {31'd0, out_valid2}, 32'd1);
        chk("l2_result", {24'd0, result2}, 32'h5A);

        // Flush drops an in-flight op and beats a same-cycle accept
        @(negedge clk);
        a = 8'h66; in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        a = 8'h77; flush2 = 1'b1;
        @(posedge clk);
        #1;
        flush2 = 1'b0; in_valid2 = 1'b0;
        chk("flush_valid", {31'd0, out_valid2}, 32'd0);
        @(posedge clk);
        #1;
        chk("flush_valid_next", {31'd0, out_valid2}, 32'd0);

        // Back-to-back stream with out_ready low for cycles 2..4
        begin
            int         sent, recv;
            logic       stalled;
            logic [12:0] held;
            logic       acc;
            sent = 0; recv = 0; stalled = 1'b0; held = '0;
            for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
                @(negedge clk);
                if (sent < 4) begin
                    op = sops[sent].op; a = sops[sent].a; b = sops[sent].b;
                    d_in = sops[sent].d; c_in = 1'b0; v_in = 1'b0;
                    in_valid2 = 1'b1;
                end else begin
                    in_valid2 = 1'b0;
                end
                out_ready2 = !(cyc >= 2 && cyc <= 4);
                #1;
                acc = in_valid2 && in_ready2;
                if (cyc == 2) chk("stream_in_ready_low", {31'd0, in_ready2}, 32'd0);
                if (out_valid2 && !out_ready2) begin
                    if (!stalled) begin
                        held = {result2, n2, z2, c2, v2, c2};
                        stalled = 1'b1;
                    end else begin
                        chk($sformatf("stream_hold_c%0d", cyc), {19'd0, result2, n2, z2, c2, v2, c2}, {19'd0, held});
                    end
                end
                if (out_valid2 && out_ready2) begin
                    stalled = 1'b0;
                    if (recv < 4) chk($sformatf("stream_out%0d", recv), {24'd0, result2}, {24'd0, sops[recv].r});
                    recv++;
                end
                @(posedge clk);
                if (acc) sent++;
            end
            in_valid2 = 1'b0; out_ready2 = 1'b1;
            chk("stream_recv_count", recv, 32'd4);
            chk("stream_sent_count", sent, 32'd4);
            @(posedge clk);
            #1;
            chk("stream_no_dup", {31'd0, out_valid2}, 32'd0);
        end

        // Async reset while a result is stalled on the output
        @(negedge clk);
        op = 4'd0; a = 8'h50; b = 8'h50; c_in = 1'b0; v_in = 1'b0; d_in = 1'b0;
        in_valid1 = 1'b1; out_ready1 = 1'b0;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        chk("mid_valid", {31'd0, out_valid1}, 32'd1);
        @(posedge clk);
        #1;
        chk("mid_hold", {24'd0, result1}, 32'hA0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", {31'd0, out_valid1}, 32'd0);
        chk("async_result", {24'd0, result1}, 32'd0);
        chk("async_flags", {24'd0, n1, z1, c1, v1, we1}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_in_ready", {31'd0, in_ready1}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the CPU core's single-cycle ALU.
- Adds the following:
  - configurable data width and pipeline depth;
  - a valid/ready handshake with backpressure;
  - a full 6502 N/Z/C/V flag set with per-op flag-write mask;
  - an optional BCD mode.
- Sits between the 6502 decode/execute sequencer and the register file / status register.

Parameters:
- WIDTH, 8: operand/result width in bits; must be ≥4 and a multiple of 4.
- LATENCY, 1: pipeline stages, legal values 1 or 2 only.
- DECIMAL_EN, 0: 1 enables BCD ADD/SUB when in_d=1; 0 ignores in_d.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous: clears all stage valid bits.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INC, 6 DEC, 7 SHR, 8 SHL, 9 RTR, 10 RTL, 11 CMP, 12 LD, 13 BIT.
- operand1  in  WIDTH  A.
- operand2  in  WIDTH  B.
- in_c  in  1  carry in.
- in_v  in  1  overflow in.
- in_d  in  1  decimal flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  R.
- flag_n, flag_z, flag_c, flag_v  out  1 each  flags.
- flag_we  out  4  {N,Z,C,V}: 1 = the op affects that flag.

Behaviour:
- Reset (async, active-high): all valid bits 0, result 0, all flags 0, flag_we 0. in_ready is 1 once reset deasserts.
- Handshake:
  - A request is accepted when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - While out_valid && !out_ready, result, flags and flag_we hold stable.
- in_ready rule:
  - LATENCY=1: in_ready = !out_valid || out_ready.
  - LATENCY=2: each stage advances when the next stage is empty or draining. in_ready = !s1_valid || stage-1 advances.
- Latency and throughput:
  - Accept at edge k → out_valid at edge k+LATENCY (absent stall).
  - Full throughput: one op per cycle.
- Flush: all valid bits 0 on the next edge; data registers don't care. flush wins over a simultaneous accept.
- Common flag rules:
  - N = R[W-1] and Z = (R==0) for all ops except BIT.
  - "Pass" means the flag output equals in_c / in_v, with its flag_we bit 0.
- ADD: {C,R} = A + B + in_c. V = (A[W-1]==B[W-1]) && (R[W-1]!=A[W-1]). we=1111.
- SUB: {C,R} = A + ~B + in_c, so C=1 means no borrow. V = (A[W-1]!=B[W-1]) && (R[W-1]!=A[W-1]). we=1111.
- CMP: as SUB with carry forced 1. R = A−B. V pass. we=1110.
- AND/OR/XOR/INC/DEC/LD: R per op (LD: R=A). INC/DEC wrap modulo 2^W. C, V pass. we=1100.
- SHR: R = A>>1, C = A[0]. SHL: R = A<<1, C = A[W-1]. V pass, we=1110.
- RTR: R = {in_c, A[W-1:1]}, C = A[0]. RTL: R = {A[W-2:0], in_c}, C = A[W-1]. V pass, we=1110.
- BIT: R = A&B. Z = (A&B)==0, N = B[W-1], V = B[W-2]. C pass. we=1101.
- Ops 14, 15: R=0, all flags pass, we=0000. No stall.
- Decimal mode (DECIMAL_EN=1 && in_d=1, ADD/SUB only):
  - Per-nibble decimal adjust from LSB upward: ADD adds 6 when nibble >9 or nibble carry; SUB subtracts 6 on nibble borrow.
  - C = decimal carry / not-borrow; N, Z taken from the adjusted R; V from the binary computation.
- Width rule: all arithmetic is done at WIDTH+1 bits internally; the MSB becomes C.

Test Plan:
- Reset asserted mid-stream with out_valid=1 → out_valid=0, result=0, flags 0 immediately (async); in_ready=1 once reset deasserts.
- ADD A=0x50, B=0x50, c=0 → R=0xA0, N=1, Z=0, C=0, V=1, we=1111. ADD A=0xFF, B=0x01, c=0 → R=0x00, Z=1, C=1, V=0.
- SUB A=0x00, B=0x01, c=1 → R=0xFF, C=0, N=1, V=0. CMP A=0x40, B=0x40 → Z=1, C=1, V=in_v, we=1110.
- RTR A=0x01, c=1 → R=0x80, C=1, N=1. BIT A=0x0F, B=0xC0 → Z=1, N=1, V=1, C=in_c, we=1101.
- LATENCY=2, back-to-back stream of 4 ops with out_ready low for 3 cycles → in_ready falls after the stages fill. Outputs held stable, none lost or duplicated, order preserved. flush → out_valid=0 next edge.
- DECIMAL_EN=1, in_d=1: ADD 0x45+0x38, c=0 → R=0x83, C=0. ADD 0x99+0x01 → R=0x00, C=1, Z=1. SUB 0x10−0x01, c=1 → R=0x09, C=1.
